pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/sat_counter.sv | 43 ++++
 rtl/pipeline_controller.sv | 163 ++++++++++++++++
 tb/tb_pipeline_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding,
// default parameter values and a small state-decoding helper.
package pipeline_pkg;

  localparam int DEF_NUM_STAGES = 5;
  localparam int DEF_WDOG_WIDTH = 8;
  localparam int DEF_PERF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_e;

  // Fetch is frozen (PC held, bubble into register 0) in both drain states.
  function automatic logic is_drain_mode(input state_e st);
    return (st == ST_DRAIN) || (st == ST_DRAINED);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign at_max = (count_q == CNT_MAX);
  assign count  = count_q;

  // Next count: clear first, otherwise step unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {WIDTH{1'b0}};
    end else if (inc && !at_max) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with asynchronous active-low reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// In-order pipeline controller: stall/flush generation from hazards,
// valids and redirects, a drain FSM, a front-end stall watchdog and two
// saturating performance counters.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int WDOG_WIDTH = DEF_WDOG_WIDTH,
  parameter int PERF_WIDTH = DEF_PERF_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NUM_STAGES-1:0] i_hazard,
  input  logic [NUM_STAGES-2:0] i_valid,
  input  logic [NUM_STAGES-1:0] i_redirect,
  input  logic                  i_drain_req,
  input  logic                  i_clear,
  output logic [NUM_STAGES-2:0] o_stall,
  output logic [NUM_STAGES-2:0] o_flush,
  output logic                  o_drained,
  output logic                  o_stall_timeout,
  output logic [PERF_WIDTH-1:0] o_stall_cycles,
  output logic [PERF_WIDTH-1:0] o_redirect_count
);

  localparam int NR = NUM_STAGES - 1;  // number of pipeline registers

  state_e          state_q;
  state_e          state_d;
  logic            drained_q;
  logic            drained_d;
  logic            timeout_q;
  logic            timeout_d;
  logic            drain_mode_s;
  logic [NR-1:0]   stall_s;
  logic [NR-1:0]   flush_s;
  logic            redirect_any_s;
  logic            wdog_inc_s;
  logic            wdog_clr_s;
  logic            wdog_max_s;
  logic [WDOG_WIDTH-1:0] wdog_count_unused_s;
  logic            redirect0_unused_s;

  // A redirect from fetch has no older register to flush, so bit 0 is dropped.
  assign redirect0_unused_s = i_redirect[0];
  assign redirect_any_s     = |i_redirect[NUM_STAGES-1:1];
  assign drain_mode_s       = is_drain_mode(state_q);

  // Stall chain from the back of the pipe forward; empty registers absorb stalls.
  always_comb begin
    stall_s = {NR{1'b0}};
    stall_s[NR-1] = i_hazard[NR];
    for (int k = NR - 2; k >= 0; k--) begin
      stall_s[k] = i_hazard[k+1] | (stall_s[k+1] & i_valid[k]);
    end
    stall_s[0] = stall_s[0] | i_hazard[0] | drain_mode_s;
  end

  // Bubble insertion at stall boundaries plus redirect squash of younger registers.
  always_comb begin
    logic redir_above;
    flush_s     = {NR{1'b0}};
    redir_above = 1'b0;
    for (int k = 1; k < NR; k++) begin
      flush_s[k] = stall_s[k-1] & ~stall_s[k];
    end
    for (int k = NR - 1; k >= 0; k--) begin
      redir_above = redir_above | i_redirect[k+1];
      flush_s[k]  = flush_s[k] | redir_above;
    end
    flush_s[0] = flush_s[0] | drain_mode_s;
  end

  assign o_stall = stall_s;
  assign o_flush = flush_s;

  // Drain FSM next state; dropping the request always returns to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (i_drain_req) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!i_drain_req) begin
          state_d = ST_RUN;
        end else if (i_valid == {NR{1'b0}}) begin
          state_d = ST_DRAINED;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAINED: begin
        if (!i_drain_req) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DRAINED;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Watchdog counts only front-end stalls in RUN; timeout is sticky until clear.
  always_comb begin
    wdog_inc_s = stall_s[0] & (state_q == ST_RUN);
    wdog_clr_s = i_clear | ~wdog_inc_s;
    drained_d  = (state_d == ST_DRAINED);
    if (i_clear) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q | (wdog_inc_s & wdog_max_s);
    end
  end

  // FSM, drained flag and timeout flag registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_RUN;
      drained_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drained_q <= drained_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_drained       = drained_q;
  assign o_stall_timeout = timeout_q;

  sat_counter #(.WIDTH(WDOG_WIDTH)) u_wdog (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .inc     (wdog_inc_s),
    .clr     (wdog_clr_s),
    .count   (wdog_count_unused_s),
    .at_max  (wdog_max_s)
  );

  sat_counter #(.WIDTH(PERF_WIDTH)) u_stall_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .inc     (stall_s[0]),
    .clr     (i_clear),
    .count   (o_stall_cycles),
    .at_max  ()
  );

  sat_counter #(.WIDTH(PERF_WIDTH)) u_redir_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .inc     (redirect_any_s),
    .clr     (i_clear),
    .count   (o_redirect_count),
    .at_max  ()
  );

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller (5 stages, 4-bit watchdog and
// 4-bit performance counters). Inputs change on the falling edge and are
// checked 1 time unit later; registered effects show one interval later.
module tb_pipeline_controller;

  logic       i_clock;
  logic       i_reset;
  logic [4:0] i_hazard;
  logic [3:0] i_valid;
  logic [4:0] i_redirect;
  logic       i_drain_req;
  logic       i_clear;
  logic [3:0] o_stall;
  logic [3:0] o_flush;
  logic       o_drained;
  logic       o_stall_timeout;
  logic [3:0] o_stall_cycles;
  logic [3:0] o_redirect_count;

  int checks;
  int failures;

  pipeline_controller #(
    .NUM_STAGES (5),
    .WDOG_WIDTH (4),
    .PERF_WIDTH (4)
  ) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_hazard         (i_hazard),
    .i_valid          (i_valid),
    .i_redirect       (i_redirect),
    .i_drain_req      (i_drain_req),
    .i_clear          (i_clear),
    .o_stall          (o_stall),
    .o_flush          (o_flush),
    .o_drained        (o_drained),
    .o_stall_timeout  (o_stall_timeout),
    .o_stall_cycles   (o_stall_cycles),
    .o_redirect_count (o_redirect_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed sequence.
  initial begin
    checks      = 0;
    failures    = 0;
    i_reset     = 1'b1;
    i_hazard    = 5'b00000;
    i_valid     = 4'b0000;
    i_redirect  = 5'b00000;
    i_drain_req = 1'b0;
    i_clear     = 1'b0;

    // I0: reset asserted; combinational rules still apply with FSM=RUN.
    #1;
    i_reset  = 1'b0;
    i_valid  = 4'b1111;
    i_hazard = 5'b01000;
    #1;
    check("rst_stall_mem", o_stall, 4'b0111);
    check("rst_flush_mem", o_flush, 4'b1000);
    check("rst_drained", o_drained, 1'b0);
    check("rst_timeout", o_stall_timeout, 1'b0);
    check("rst_stall_cycles", o_stall_cycles, 4'd0);
    check("rst_redirect_count", o_redirect_count, 4'd0);

    // I1: empty register 1 absorbs the MEM stall.
    @(negedge i_clock);
    i_reset = 1'b1;
    i_valid = 4'b1101;
    #1;
    check("absorb_stall", o_stall, 4'b0100);
    check("absorb_flush", o_flush, 4'b1000);

    // I2: redirect from stage 2 with hazard in stage 1.
    @(negedge i_clock);
    i_valid    = 4'b1111;
    i_hazard   = 5'b00010;
    i_redirect = 5'b00100;
    #1;
    check("redir2_stall", o_stall, 4'b0001);
    check("redir2_flush", o_flush, 4'b0011);
    check("redir_count_before", o_redirect_count, 4'd0);

    // I3: redirect from the last stage flushes every register.
    @(negedge i_clock);
    i_valid    = 4'b0000;
    i_hazard   = 5'b00000;
    i_redirect = 5'b10000;
    #1;
    check("redir4_stall", o_stall, 4'b0000);
    check("redir4_flush", o_flush, 4'b1111);
    check("redir_count_1", o_redirect_count, 4'd1);
    check("stall_cycles_1", o_stall_cycles, 4'd1);

    // I4: redirect bit 0 is ignored.
    @(negedge i_clock);
    i_redirect = 5'b00001;
    #1;
    check("redir0_flush", o_flush, 4'b0000);
    check("redir_count_2", o_redirect_count, 4'd2);

    // I5
    @(negedge i_clock);
    i_redirect = 5'b00000;
    #1;
    check("redir0_not_counted", o_redirect_count, 4'd2);

    // I6: drain request seen in RUN.
    @(negedge i_clock);
    i_drain_req = 1'b1;
    i_valid     = 4'b0111;
    #1;
    check("drain_req_run_stall", o_stall, 4'b0000);
    check("drain_req_run_drained", o_drained, 1'b0);

    // I7..I10: drain with valids emptying.
    @(negedge i_clock);
    #1;
    check("drain_a_stall", o_stall, 4'b0001);
    check("drain_a_flush", o_flush, 4'b0011);
    @(negedge i_clock);
    i_valid = 4'b0110;
    #1;
    check("drain_b_stall0", o_stall[0], 1'b1);
    check("drain_b_flush0", o_flush[0], 1'b1);
    @(negedge i_clock);
    i_valid = 4'b0100;
    #1;
    check("drain_c_flush0", o_flush[0], 1'b1);
    check("drain_c_drained", o_drained, 1'b0);
    @(negedge i_clock);
    i_valid = 4'b0000;
    #1;
    check("drain_d_stall0", o_stall[0], 1'b1);
    check("drain_d_drained", o_drained, 1'b0);

    // I11: empty sampled last interval -> DRAINED.
    @(negedge i_clock);
    #1;
    check("drained_set", o_drained, 1'b1);
    check("drained_stall0", o_stall[0], 1'b1);
    check("drained_flush0", o_flush[0], 1'b1);

    // I12: release request.
    @(negedge i_clock);
    i_drain_req = 1'b0;
    #1;
    check("drained_hold", o_drained, 1'b1);

    // I13: back in RUN.
    @(negedge i_clock);
    #1;
    check("run_drained_clr", o_drained, 1'b0);
    check("run_stall", o_stall, 4'b0000);
    check("run_flush", o_flush, 4'b0000);
    check("stall_cycles_7", o_stall_cycles, 4'd7);

    // I14..I17: abort a drain before the pipe empties.
    @(negedge i_clock);
    i_drain_req = 1'b1;
    i_valid     = 4'b0001;
    @(negedge i_clock);
    #1;
    check("abort_drain_flush0", o_flush[0], 1'b1);
    @(negedge i_clock);
    i_drain_req = 1'b0;
    @(negedge i_clock);
    #1;
    check("abort_stall0", o_stall[0], 1'b0);
    check("abort_flush0", o_flush[0], 1'b0);
    check("abort_drained", o_drained, 1'b0);

    // I18..I19: reset in the middle of a drain.
    @(negedge i_clock);
    i_drain_req = 1'b1;
    @(negedge i_clock);
    #1;
    check("pre_rst_drain_stall0", o_stall[0], 1'b1);
    i_drain_req = 1'b0;
    i_reset     = 1'b0;
    #1;
    check("mid_rst_stall0", o_stall[0], 1'b0);
    check("mid_rst_stall_cycles", o_stall_cycles, 4'd0);
    check("mid_rst_redirect_count", o_redirect_count, 4'd0);

    // I20..I39: fetch hazard held 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clock);
      i_reset  = 1'b1;
      i_valid  = 4'b0000;
      i_hazard = 5'b00001;
      #1;
      if (i == 15) begin
        check("wdog_not_yet", o_stall_timeout, 1'b0);
        check("stall_cycles_15", o_stall_cycles, 4'd15);
      end
      if (i == 16) begin
        check("wdog_timeout", o_stall_timeout, 1'b1);
      end
    end

    // I40: hazard drops; timeout sticky, counter saturated.
    @(negedge i_clock);
    i_hazard = 5'b00000;
    #1;
    check("timeout_sticky", o_stall_timeout, 1'b1);
    check("stall_cycles_sat", o_stall_cycles, 4'd15);

    // I41: clear coincides with a stall.
    @(negedge i_clock);
    i_hazard = 5'b00001;
    i_clear  = 1'b1;
    #1;
    check("timeout_before_clear", o_stall_timeout, 1'b1);

    // I42: clear won.
    @(negedge i_clock);
    i_hazard = 5'b00000;
    i_clear  = 1'b0;
    #1;
    check("timeout_cleared", o_stall_timeout, 1'b0);
    check("stall_cycles_cleared", o_stall_cycles, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
